sec_encoder_cyclic_52bits_clk: RTL
==================================

// Module: sec_encoder_cyclic_52bits_clk
// PURPOSE
//  Bit-serial systematic SEC encoder. It turns a 52-bit data word into a 61-bit codeword
//  using a shortened cyclic Hamming code with g(x)=x^9+x^4+1.
//  It is the transmit-side counterpart of the 52-bit SEC location decoder: its codeword W
//  drives the decoder's W input directly.
//  Data is accepted with a valid/ready handshake, shifted through a 9-bit LFSR at one bit
//  per clock, and presented as a held codeword with a valid/ready handshake.
// PARAMETERS
//  DATA_BITS  52      data word width
//  PAR_BITS   9       check bits (degree of g(x))
//  GEN_POLY   9'h011  g(x) low-order terms (x^4+1); the x^9 term is implicit
//  W_BITS     61      localparam = DATA_BITS+PAR_BITS; codeword width
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous active-low reset
//  in_valid   in   1          D is valid
//  in_ready   out  1          encoder can accept D
//  D          in   DATA_BITS  data word
//  out_valid  out  1          W holds a complete codeword
//  out_ready  in   1          consumer takes W
//  W          out  W_BITS     codeword: W[60:9]=D, W[8:0]=x^9*D(x) mod g(x)
//  busy       out  1          high in SHIFT or DONE
// BEHAVIOUR
//  Reset: on any clk edge with rst_n=0.
//   - state<=IDLE; lfsr, cnt, W and data reg all cleared.
//   - Outputs: out_valid=0, busy=0, W=0, in_ready=1 from the first cycle after reset.
//   - Reset mid-SHIFT or mid-DONE discards the word in progress; no partial W is ever
//     flagged valid.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: in_ready=1.
//     - On in_valid&&in_ready: latch D; lfsr<=0; cnt<=0; go to SHIFT.
//   - SHIFT: in_ready=0. Each cycle processes one data bit, MSB first.
//     - bit = data[DATA_BITS-1-cnt]
//     - fb = bit ^ lfsr[8]
//     - lfsr <= {lfsr[7:0],1'b0} ^ (fb ? GEN_POLY : 0)
//     - cnt <= cnt+1
//     - In the cycle that processes cnt==DATA_BITS-1: register W={data, next lfsr}; go to DONE.
//   - DONE: out_valid=1; W and out_valid stay stable until out_ready=1.
//     - On out_valid&&out_ready: go to IDLE; out_valid=0 on the next cycle.
//  Latency: accept edge at E0 -> out_valid high after edge E52 (52 clocks).
//  Throughput: at most one word per 54 clocks, with out_ready tied high.
//  Handshake rules:
//   - in_ready is a pure function of state (IDLE only).
//   - in_valid is ignored outside IDLE; D changes during SHIFT have no effect.
//   - out_ready is ignored when out_valid=0.
//   - A new word is not accepted in the same cycle as the DONE->IDLE handoff;
//     in_ready rises one cycle later.
//  cnt: 6 bits, never wraps; it is compared only against DATA_BITS-1.
//  All arithmetic is XOR over GF(2); there are no carries.
// TESTING
//  1. Reset mid-SHIFT: rst_n=0 for one edge at shift cycle 20 -> next cycle out_valid=0,
//     in_ready=1, W=0.
//  2. D=0 -> W=61'h0; out_valid rises exactly 52 clocks after the accept edge.
//  3. D=52'h1 -> W=61'h211. D=52'h2 -> W=61'h422. Each is held stable under
//     out_ready=0 for 10 cycles.
//  4. Handshake: in_valid held high across DONE with out_ready pulsed.
//     -> Exactly one accept per codeword.
//     -> in_ready low throughout SHIFT/DONE.
//     -> in_ready high one cycle after the out handshake.
//  5. Loopback: random D (1000 words) -> W feeds sec_decoder_location_52bits_clk; the
//     decoder reports no error.
//     - Each W also matches a software LFSR model.
//  6. Single-bit flips: W^(1<<k) for k=0..60 into the decoder -> error location k is
//     reported and corrected.

Source files
------------

// File: rtl/sec_encoder_cyclic_52bits_clk.sv
// Bit-serial systematic encoder for the shortened cyclic Hamming code g(x)=x^9+x^4+1.
// Data is shifted MSB first through a 9-bit LFSR; the codeword is held until taken.
module sec_encoder_cyclic_52bits_clk #(
  parameter int unsigned DATA_BITS = 52,
  parameter int unsigned PAR_BITS  = 9,
  parameter logic [PAR_BITS-1:0] GEN_POLY = 9'h011,
  localparam int unsigned W_BITS   = DATA_BITS + PAR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] D,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_BITS-1:0]    W,
  output logic                 busy,
  output logic [1:0]           fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the payload is stable while valid is high.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(DATA_BITS - 1);

  state_t                state;
  logic [DATA_BITS-1:0]  data;
  logic [PAR_BITS-1:0]   lfsr;
  logic [PAR_BITS-1:0]   lfsr_next;
  logic [5:0]            cnt;
  logic [5:0]            idx;
  logic                  fb;
  logic [W_BITS-1:0]     code;
  logic                  out_valid_r;

  // cnt walks 0..DATA_BITS-1, so the bit index walks MSB down to LSB.
  assign idx = LAST - cnt;

  always_comb begin
    fb        = data[idx] ^ lfsr[PAR_BITS-1];
    lfsr_next = {lfsr[PAR_BITS-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      data        <= '0;
      lfsr        <= '0;
      cnt         <= '0;
      code        <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= D;
            lfsr  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_next;
          cnt  <= cnt + 6'd1;
          if (cnt == LAST) begin
            code        <= {data, lfsr_next};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign W         = code;
  assign fsm_state = state;

endmodule
